gray_code_burst_counter: RTL and testbench
==========================================

Name: gray_code_burst_counter

Overview:
- Upstream producer for the gray-to-binary conversion stage.
- Generates a burst of consecutive gray-coded count values from a binary start value, counting up or down.
- Presents each value on a valid/ready stream and holds it stable under backpressure.
- Consecutive accepted values always differ in exactly one bit, so downstream logic can rely on single-bit transitions.

Parameters:
N, 4, count width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
start_value  input  N  binary value of the first element of the burst
count_len  input  N  number of values in the burst; 0 means 2^N
up  input  1  direction: 1 = increment, 0 = decrement; captured at start
gray_value  output  N  current gray-coded element, registered
out_valid  output  1  gray_value is valid
out_ready  input  1  downstream accepts gray_value this cycle
wrap  output  1  high while the presented element wrapped (2^N-1 -> 0 up, or 0 -> 2^N-1 down)
busy  output  1  burst in progress (state RUN)
done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Clock, reset, and polarity (already decided): one clock clk; reset rstn is asynchronous, active-low.
- Reset: on rstn low, immediately, at any time including mid-burst:
  - state = IDLE
  - gray_value, out_valid, wrap, busy, done = 0
  - internal binary count and remaining count = 0
- Accept = out_valid && out_ready.
- Gray conversion: gray_value = bin ^ (bin >> 1), computed from the internal binary count and registered with it.
- States: IDLE, RUN, DONE.
- IDLE:
  - out_valid = 0, busy = 0.
  - start = 1: capture bin = start_value, dir = up, remaining = count_len (0 loads 2^N, so remaining is N+1 bits wide).
  - Next cycle: RUN, out_valid = 1, gray_value = gray(start_value), wrap = 0. Latency start -> first valid = 1 cycle.
- RUN:
  - busy = 1.
  - No accept: gray_value, out_valid, and wrap held stable.
  - start is ignored.
  - Accept with remaining == 1: next cycle DONE, out_valid = 0, wrap = 0.
  - Accept with remaining > 1: next cycle:
    - bin = bin ± 1 mod 2^N
    - remaining decrements
    - gray_value updated
    - wrap = 1 if this step crossed the boundary, else 0
  - One element per cycle at full throughput.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, out_valid = 0.
  - start is ignored in DONE.
  - Next state: IDLE.
- Arithmetic: all count arithmetic is modulo 2^N; no saturation. A 2^N-length burst visits every code exactly once.
- Inputs start_value, count_len, and up have no effect outside IDLE.
- out_ready has no effect when out_valid = 0.

Optional Feature:
- Macro: GRAY_CNT_PARITY_EN
- Defined:
  - Adds output port parity_out (1 bit) = XOR of all bits of gray_value, registered alongside gray_value.
  - Reset value 0.
  - Also adds an internal check that flags any accepted step where parity does not toggle: assertion in simulation, sticky output parity_err (1 bit, cleared only by reset).
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
1. Reset: drive rstn = 0 mid-RUN with out_valid = 1 -> same cycle gray_value = 0000, out_valid = 0, busy = 0; after release, IDLE until start.
2. Up burst: N = 4, start_value = 0, count_len = 4, up = 1, out_ready = 1 -> gray_value 0000, 0001, 0011, 0010 on 4 consecutive cycles; then done = 1 for one cycle with out_valid = 0; then IDLE.
3. Up wrap: start_value = 14, count_len = 3, up = 1 -> binary 14, 15, 0 -> gray 1001, 1000, 0000; wrap = 1 only while 0000 is presented.
4. Down wrap: start_value = 1, count_len = 3, up = 0 -> gray 0001, 0000, 1000; wrap = 1 only with 1000.
5. Backpressure: count_len = 5, out_ready = 0 for 3 cycles while 0011 is presented -> 0011 and out_valid = 1 held all 3 cycles; sequence resumes with 0010 after the accept; total of 5 accepts.
6. Full cycle and start while busy: count_len = 0, start_value = 5 -> 16 accepts covering all 16 codes, each with a single-bit change; start pulsed mid-burst is ignored (burst length stays 16); exactly one wrap pulse.

Source files
------------

// File: rtl/gray_code_burst_counter_if.sv
// Output stream of the gray-code burst counter: registered gray value with
// its valid/ready handshake and the wrap marker that travels with each element.
interface gray_code_burst_counter_if #(
    parameter int N = 4
);
    // Handshake: an element transfers on a rising clk edge where out_valid and
    // out_ready are both high. While out_valid is high and out_ready is low,
    // gray_value and wrap stay stable. out_ready is ignored while out_valid is low.
    logic [N-1:0] gray_value;
    logic         out_valid;
    logic         out_ready;
    logic         wrap;

    modport master (
        output gray_value,
        output out_valid,
        output wrap,
        input  out_ready
    );

    modport slave (
        input  gray_value,
        input  out_valid,
        input  wrap,
        output out_ready
    );
endinterface

// File: rtl/gray_code_burst_counter.sv
// Burst generator of consecutive gray codes (up or down) on a valid/ready stream.
// Optional GRAY_CNT_PARITY_EN adds parity_out and a sticky parity_err checker.
module gray_code_burst_counter #(
    parameter int N = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [N-1:0]                    start_value,
    input  logic [N-1:0]                    count_len,
    input  logic                            up,
    gray_code_burst_counter_if.master       sif,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      state_dbg
`ifdef GRAY_CNT_PARITY_EN
    ,
    output logic                            parity_out,
    output logic                            parity_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [N:0]   REM_ONE = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0] BIN_ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic [N:0]   rem_q, rem_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic         accept;
    logic         step;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign accept = (state_q == RUN) && sif.out_ready;
    assign step   = accept && (rem_q != REM_ONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        gray_d  = gray_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    bin_d   = start_value;
                    gray_d  = to_gray(start_value);
                    dir_d   = up;
                    // A zero length means a full 2^N burst, hence the extra rem bit.
                    rem_d   = (count_len == '0) ? {1'b1, {N{1'b0}}} : {1'b0, count_len};
                    wrap_d  = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (rem_q == REM_ONE) begin
                        state_d = DONE;
                        wrap_d  = 1'b0;
                    end else begin
                        bin_d  = dir_q ? (bin_q + BIN_ONE) : (bin_q - BIN_ONE);
                        gray_d = to_gray(bin_d);
                        rem_d  = rem_q - REM_ONE;
                        wrap_d = dir_q ? (&bin_q) : (~|bin_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sif.gray_value = gray_q;
    assign sif.out_valid  = (state_q == RUN);
    assign sif.wrap       = wrap_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign state_dbg      = state_q;

`ifdef GRAY_CNT_PARITY_EN
    logic parity_q, parity_d;
    logic perr_q, perr_d;

    // Every accepted step changes one gray bit, so parity must flip with it.
    always_comb begin
        parity_d = ^gray_d;
        perr_d   = perr_q | (step && (parity_d == parity_q));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            parity_q <= parity_d;
            perr_q   <= perr_d;
        end
    end

    assign parity_out = parity_q;
    assign parity_err = perr_q;

    parity_toggle_a: assert property (@(posedge clk) disable iff (!rstn)
        !(step && (parity_d == parity_q)));
`endif

endmodule

// File: tb/tb_gray_code_burst_counter.sv
// Directed bench for gray_code_burst_counter: hand-computed gray sequences
// queued as expectations and compared element by element on the stream.
module tb_gray_code_burst_counter;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [3:0] start_value;
  logic [3:0] count_len;
  logic       up;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  gray_code_burst_counter_if #(.N(4)) sif ();

  gray_code_burst_counter #(.N(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .start_value (start_value),
    .count_len   (count_len),
    .up          (up),
    .sif         (sif),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] exp_q[$];
  logic       wexp_q[$];
  logic [15:0] seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic w);
    exp_q.push_back(g);
    wexp_q.push_back(w);
  endtask

  // Runs one burst; stalls out_ready for stall_n cycles when element stall_idx
  // is presented, and optionally pulses start mid-burst.
  task automatic run_burst(input logic [3:0] sv, input logic [3:0] len, input logic dir,
                           input int stall_idx, input int stall_n, input bit poke);
    int acc = 0;
    int stalls = 0;
    int cyc = 0;
    logic [3:0] last = '0;
    seen = '0;
    @(negedge clk);
    start = 1'b1; start_value = sv; count_len = len; up = dir; sif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_value = 4'($urandom_range(0, 15));
    count_len = 4'($urandom_range(1, 15));
    up = ~dir;
    check_eq("first_valid", sif.out_valid, 1);
    while (exp_q.size() != 0 && cyc < 100) begin
      cyc++;
      start = 1'b0;
      check_eq("valid", sif.out_valid, 1);
      check_eq("busy", busy, 1);
      check_eq("state_run", state_dbg, 2'd1);
      check_eq("gray", sif.gray_value, exp_q[0]);
      check_eq("wrap", sif.wrap, wexp_q[0]);
      if (acc == stall_idx && stalls < stall_n) begin
        sif.out_ready = 1'b0;
        stalls++;
      end else begin
        sif.out_ready = 1'b1;
        if (acc > 0) check_eq("one_bit", $countones(last ^ sif.gray_value), 1);
        last = sif.gray_value;
        seen[sif.gray_value] = 1'b1;
        void'(exp_q.pop_front());
        void'(wexp_q.pop_front());
        acc++;
        if (poke && acc == 5) begin
          start = 1'b1; start_value = 4'd0; count_len = 4'd2; up = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("burst_timeout", (cyc < 100), 1);
    check_eq("done_pulse", done, 1);
    check_eq("done_valid", sif.out_valid, 0);
    check_eq("done_busy", busy, 0);
    check_eq("done_wrap", sif.wrap, 0);
    check_eq("state_done", state_dbg, 2'd2);
    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_valid", sif.out_valid, 0);
    check_eq("state_idle", state_dbg, 2'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; start_value = '0; count_len = '0; up = 1'b1;
    sif.out_ready = 1'b0;
    #1;
    check_eq("rst_gray", sif.gray_value, 0);
    check_eq("rst_valid", sif.out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wrap", sif.wrap, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Up burst from 0, length 4
    push(4'b0000, 0); push(4'b0001, 0); push(4'b0011, 0); push(4'b0010, 0);
    run_burst(4'd0, 4'd4, 1'b1, -1, 0, 1'b0);

    // Up wrap: binary 14, 15, 0
    push(4'b1001, 0); push(4'b1000, 0); push(4'b0000, 1);
    run_burst(4'd14, 4'd3, 1'b1, -1, 0, 1'b0);

    // Down wrap: binary 1, 0, 15
    push(4'b0001, 0); push(4'b0000, 0); push(4'b1000, 1);
    run_burst(4'd1, 4'd3, 1'b0, -1, 0, 1'b0);

    // Backpressure: stall 3 cycles while 0011 is presented
    push(4'b0000, 0); push(4'b0001, 0); push(4'b0011, 0); push(4'b0010, 0); push(4'b0110, 0);
    run_burst(4'd0, 4'd5, 1'b1, 2, 3, 1'b0);

    // Full 16-code burst from 5 with a start pulse mid-burst
    push(4'b0111, 0); push(4'b0101, 0); push(4'b0100, 0); push(4'b1100, 0);
    push(4'b1101, 0); push(4'b1111, 0); push(4'b1110, 0); push(4'b1010, 0);
    push(4'b1011, 0); push(4'b1001, 0); push(4'b1000, 0); push(4'b0000, 1);
    push(4'b0001, 0); push(4'b0011, 0); push(4'b0010, 0); push(4'b0110, 0);
    run_burst(4'd5, 4'd0, 1'b1, -1, 0, 1'b1);
    check_eq("all_codes", seen, 16'hFFFF);

    // Idle: ready toggling without start leaves the counter idle
    sif.out_ready = 1'b0;
    @(negedge clk);
    sif.out_ready = 1'b1;
    @(negedge clk);
    check_eq("idle_hold_valid", sif.out_valid, 0);
    check_eq("idle_hold_busy", busy, 0);

    // Asynchronous reset mid-RUN
    start = 1'b1; start_value = 4'd5; count_len = 4'd8; up = 1'b1; sif.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("pre_rst_valid", sif.out_valid, 1);
    check_eq("pre_rst_gray", sif.gray_value, 4'b0111);
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_gray", sif.gray_value, 0);
    check_eq("mid_rst_valid", sif.out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_state", state_dbg, 2'd0);
    @(negedge clk);
    rstn = 1'b1;
    sif.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_idle", sif.out_valid, 0);
      check_eq("post_rst_busy", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
